chd_perm_ctrl: RTL and testbench
================================

# chd_perm_ctrl

Sequencing controller for the OSD codeword-permutation stage. It loads the inverse permutation tables λ1⁻¹ and λ2⁻¹ serially, one index per cycle, and checks that each table is a bijection. It then streams codewords through the two-stage inverse permutation under a valid/ready handshake, with one registered output stage. It sits between the OSD reliability-sorting front end, which supplies the tables, and the Gaussian-elimination/re-encoding stage, which consumes the permuted codewords.

## Interface
Parameters:
- N, default 64, codeword length and permutation size.
- W, default $clog2(N), index width.

Ports:
- clk  in  1  Single clock; all logic is on the rising edge.
- rst  in  1  Asynchronous reset, active-high.
- cfg_start  in  1  One-cycle pulse. Clears the tables' bookkeeping and starts a load.
- cfg_valid  in  1  Table entry present on cfg_lam1/cfg_lam2.
- cfg_lam1  in  W  λ1⁻¹ entry for the current load index.
- cfg_lam2  in  W  λ2⁻¹ entry for the current load index.
- cfg_done  out  1  Tables loaded and valid; block is in RUN.
- cfg_err  out  1  Last load contained a duplicate or out-of-range entry; block is in ERR.
- in_valid  in  1  Codeword offered.
- in_ready  out  1  Codeword accepted when in_valid && in_ready.
- in_codeword  in  N  Codeword bits.
- out_valid  out  1  Permuted codeword held.
- out_ready  in  1  Downstream accepts.
- out_chd  out  N  Permuted codeword.

## Operation
- Tables: lam1[0..N-1] and lam2[0..N-1] registers, W bits each.
- Transform: tmp[j] = in_codeword[lam2[j]]; out_chd[i] = tmp[lam1[i]]. Equivalently, out_chd[i] = in_codeword[lam2[lam1[i]]].
- FSM states and transitions:
  - IDLE: after reset. cfg_start → LOAD.
  - LOAD: the load index idx runs 0..N-1. Each cycle with cfg_valid: write lam1[idx] ← cfg_lam1 and lam2[idx] ← cfg_lam2, then idx++.
    - When the entry at idx = N-1 is accepted: go to RUN if the sticky error is clear, otherwise go to ERR.
    - cfg_start during LOAD restarts the load: idx ← 0, seen maps cleared, error cleared.
  - RUN: streams codewords. cfg_start → LOAD.
  - ERR: no streaming. cfg_start → LOAD.
- Bijection check, using N-bit maps seen1 and seen2 that are cleared on cfg_start:
  - An entry that is ≥ N (possible only when N is not a power of two) sets the sticky error.
  - An entry whose bit is already set in seen1 or seen2 sets the sticky error.
  - Otherwise set that entry's bit in the map.
  - The load always consumes all N entries, even after an error.
- cfg_valid outside LOAD is ignored.
- If cfg_start and cfg_valid are asserted in the same cycle, cfg_start wins and the entry is dropped.
- Flow control:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - On an input handshake, out_chd ← transform(in_codeword) and out_valid ← 1.
  - out_valid clears on an output handshake with no simultaneous input.
  - Simultaneous input and output handshakes in the same cycle give back-to-back throughput of one codeword per cycle.
- cfg_start while out_valid=1 clears out_valid on the next edge. The held codeword is discarded.
- Tables are never modified outside LOAD.

## Timing
- Reset values:
  - State IDLE, idx=0.
  - cfg_done=0, cfg_err=0, in_ready=0, out_valid=0, out_chd=0.
  - Tables, seen maps and error flag all 0.
- cfg_start sampled at edge t: state is LOAD after t, and cfg_done/cfg_err are 0 from t+1.
- Final entry (idx=N-1) sampled at edge t: cfg_done=1 (or cfg_err=1) after t, and in_ready may be 1 in the cycle after t.
- Minimum load time: N cycles after the cfg_start cycle.
- Latency: an input handshake at edge t gives out_valid=1 with the data after t (1 cycle).
- out_chd and out_valid are registered and stay stable while out_valid && !out_ready.
- in_ready is combinational from the state and out_ready only; it has no path from in_valid.
- Asynchronous rst mid-load or mid-stream: everything returns to reset values immediately, including the tables. A new load is required after reset.

## Test plan
- N=8, identity tables (lam1=lam2=[0..7]), codeword 8'hA5: out_chd=8'hA5 one cycle after the handshake; cfg_done=1 after the 8th entry.
- N=8, lam2=[7,6,5,4,3,2,1,0], lam1=[1,0,3,2,5,4,7,6], codeword 8'b0000_0001 (bit0=1): only bit6 of out_chd is set.
  - Derivation: out_chd[i] = cw[lam2[lam1[i]]], so bit0 maps to i where lam2[lam1[i]]=0, i.e. lam1[i]=7, giving i=6.
- Load with lam1 having entry 3 twice: cfg_err=1, cfg_done=0, and in_ready stays 0 while in_valid=1.
  - Follow-up: cfg_start and a valid reload lead to RUN.
- Streaming, 16 back-to-back codewords, out_ready toggled pseudo-randomly: output order and values match the model, with no loss or duplication. out_chd stays stable while stalled.
- cfg_start in RUN while out_valid=1 and out_ready=0: out_valid=0 next cycle, in_ready=0 throughout the reload, and cfg_done returns to 1 after N entries.
- rst asserted at load index 4: outputs go to 0 immediately. A subsequent cfg_valid without cfg_start is ignored and the state stays IDLE.

Source files
------------

// File: rtl/chd_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : chd_perm_ctrl
// Description : Sequencing controller for the OSD codeword-permutation stage.
//               Loads the inverse permutation tables lam1/lam2 serially (one
//               index per cycle), checks each table is a bijection, then
//               streams codewords through out_chd[i] = in_codeword[lam2[lam1[i]]]
//               under valid/ready with a single registered output stage.
// Ports       : clk, rst (async, active-high)
//               cfg_start/cfg_valid/cfg_lam1/cfg_lam2 : table load interface
//               cfg_done/cfg_err                      : load status (RUN / ERR)
//               in_valid/in_ready/in_codeword         : codeword input
//               out_valid/out_ready/out_chd           : permuted codeword output
// Revision    : 1.0 - initial release
// ============================================================================
module chd_perm_ctrl #(
    parameter int N = 64,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_start,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_lam1,
    input  logic [W-1:0] cfg_lam2,
    output logic         cfg_done,
    output logic         cfg_err,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_codeword,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_chd
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_LOAD = 2'd1;
    localparam logic [1:0] c_ST_RUN  = 2'd2;
    localparam logic [1:0] c_ST_ERR  = 2'd3;

    // One extra bit so the range compare is meaningful when N is a power of two.
    localparam logic [W:0]   c_N_EXT    = (W+1)'(N);
    localparam logic [W-1:0] c_IDX_LAST = W'(N-1);

    logic [1:0]   r_state;
    logic [W-1:0] r_idx;
    logic [W-1:0] r_lam1 [N];
    logic [W-1:0] r_lam2 [N];
    logic [N-1:0] r_seen1;
    logic [N-1:0] r_seen2;
    logic         r_err;
    logic         r_cfg_done;
    logic         r_cfg_err;
    logic         r_out_valid;
    logic [N-1:0] r_out_chd;

    logic         w_oor1;
    logic         w_oor2;
    logic         w_dup1;
    logic         w_dup2;
    logic         w_entry_err;
    logic         w_load_wr;
    logic         w_in_hs;
    logic         w_out_hs;
    logic [N-1:0] w_perm;

    // Entry checks for the index currently offered on the config bus.
    assign w_oor1      = ({1'b0, cfg_lam1} >= c_N_EXT);
    assign w_oor2      = ({1'b0, cfg_lam2} >= c_N_EXT);
    assign w_dup1      = !w_oor1 && r_seen1[cfg_lam1];
    assign w_dup2      = !w_oor2 && r_seen2[cfg_lam2];
    assign w_entry_err = w_oor1 || w_oor2 || w_dup1 || w_dup2;

    // cfg_start has priority: an entry offered in the same cycle is dropped.
    assign w_load_wr = (r_state == c_ST_LOAD) && cfg_valid && !cfg_start;

    // Ready depends only on state and downstream acceptance, never on in_valid.
    assign in_ready = (r_state == c_ST_RUN) && (!r_out_valid || out_ready);
    assign w_in_hs  = in_valid && in_ready;
    assign w_out_hs = r_out_valid && out_ready;

    // Two-stage inverse permutation collapsed into one composed lookup.
    always_comb begin
        w_perm = '0;
        for (int i = 0; i < N; i++) begin
            w_perm[i] = in_codeword[r_lam2[r_lam1[i]]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= '0;
            r_seen1     <= '0;
            r_seen2     <= '0;
            r_err       <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_chd   <= '0;
            for (int i = 0; i < N; i++) begin
                r_lam1[i] <= '0;
                r_lam2[i] <= '0;
            end
        end else if (cfg_start) begin
            // Restart from any state; a held output codeword is discarded.
            r_state     <= c_ST_LOAD;
            r_idx       <= '0;
            r_seen1     <= '0;
            r_seen2     <= '0;
            r_err       <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load_wr) begin
                r_lam1[r_idx] <= cfg_lam1;
                r_lam2[r_idx] <= cfg_lam2;
                if (!w_oor1) begin
                    r_seen1[cfg_lam1] <= 1'b1;
                end
                if (!w_oor2) begin
                    r_seen2[cfg_lam2] <= 1'b1;
                end
                if (w_entry_err) begin
                    r_err <= 1'b1;
                end
                // All N entries are always consumed, even after an error.
                if (r_idx == c_IDX_LAST) begin
                    r_idx <= '0;
                    if (r_err || w_entry_err) begin
                        r_state   <= c_ST_ERR;
                        r_cfg_err <= 1'b1;
                    end else begin
                        r_state    <= c_ST_RUN;
                        r_cfg_done <= 1'b1;
                    end
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end

            if (w_in_hs) begin
                r_out_chd   <= w_perm;
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign cfg_done  = r_cfg_done;
    assign cfg_err   = r_cfg_err;
    assign out_valid = r_out_valid;
    assign out_chd   = r_out_chd;

endmodule
`default_nettype wire

// File: tb/tb_chd_perm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_chd_perm_ctrl
// Description : Self-checking bench for chd_perm_ctrl with N=8. Table vectors
//               cover identity, composed, error and reload cases; directed
//               sequences cover streaming with backpressure, reload from RUN
//               with a held output, and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chd_perm_ctrl;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic         cfg_start;
    logic         cfg_valid;
    logic [W-1:0] cfg_lam1;
    logic [W-1:0] cfg_lam2;
    logic         cfg_done;
    logic         cfg_err;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_codeword;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_chd;

    chd_perm_ctrl #(.N(N), .W(W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_start   (cfg_start),
        .cfg_valid   (cfg_valid),
        .cfg_lam1    (cfg_lam1),
        .cfg_lam2    (cfg_lam2),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_codeword (in_codeword),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_chd     (out_chd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tables are packed one entry per nibble: entry i = tbl[4*i +: 3].
    typedef struct {
        logic [31:0] l1;
        logic [31:0] l2;
        logic [7:0]  cw;
        logic [7:0]  exp_chd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];
    int   n_assert;
    int   n_fail;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [31:0] l1, input logic [31:0] l2,
                                         input logic [7:0] cw);
        logic [7:0] m;
        int j;
        int k;
        m = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(l1[4*i +: 3]);
            k = int'(l2[4*j +: 3]);
            m[i] = cw[k];
        end
        return m;
    endfunction

    // Start pulse (with a junk entry that must be dropped), then N entries.
    task automatic do_load(input logic [31:0] l1, input logic [31:0] l2);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_lam1  = 3'd5;
        cfg_lam2  = 3'd5;
        tick();
        cfg_start = 1'b0;
        chk("start_clears_done", cfg_done, 0);
        chk("start_clears_err", cfg_err, 0);
        chk("start_clears_out_valid", out_valid, 0);
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            cfg_valid = 1'b1;
            cfg_lam1  = l1[4*i +: 3];
            cfg_lam2  = l2[4*i +: 3];
            #1;
            chk("load_in_ready_low", in_ready, 0);
            tick();
            if (i == N-2) begin
                chk("early_done_low", cfg_done | cfg_err, 0);
            end
        end
        cfg_valid = 1'b0;
    endtask

    logic [7:0] exp_q [$];
    logic [7:0] cws   [16];
    logic [7:0] held_v;
    logic [7:0] exp_v;
    logic       held;
    logic       hs_in;
    logic       hs_out;
    int         sent;
    int         rcvd;
    int         cyc;

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        cfg_start   = 1'b0;
        cfg_valid   = 1'b0;
        cfg_lam1    = '0;
        cfg_lam2    = '0;
        in_valid    = 1'b0;
        in_codeword = '0;
        out_ready   = 1'b1;

        vecs[0] = '{l1: 32'h76543210, l2: 32'h76543210, cw: 8'hA5, exp_chd: 8'hA5, exp_err: 1'b0};
        vecs[1] = '{l1: 32'h67452301, l2: 32'h01234567, cw: 8'h01, exp_chd: 8'h40, exp_err: 1'b0};
        vecs[2] = '{l1: 32'h76533210, l2: 32'h76543210, cw: 8'h00, exp_chd: 8'h00, exp_err: 1'b1};
        vecs[3] = '{l1: 32'h76543210, l2: 32'h01234567, cw: 8'h0F, exp_chd: 8'hF0, exp_err: 1'b0};
        vecs[4] = '{l1: 32'h76543210, l2: 32'h76543200, cw: 8'h00, exp_chd: 8'h00, exp_err: 1'b1};
        vecs[5] = '{l1: 32'h07654321, l2: 32'h76543210, cw: 8'h03, exp_chd: 8'h81, exp_err: 1'b0};

        #2;
        chk("reset_cfg_done", cfg_done, 0);
        chk("reset_cfg_err", cfg_err, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_chd", out_chd, 0);
        #10;
        rst = 1'b0;
        tick();

        // Table-driven load + single codeword cases.
        for (int v = 0; v < 6; v++) begin
            do_load(vecs[v].l1, vecs[v].l2);
            chk("vec_cfg_done", cfg_done, !vecs[v].exp_err);
            chk("vec_cfg_err", cfg_err, vecs[v].exp_err);
            in_valid    = 1'b1;
            in_codeword = vecs[v].cw;
            if (vecs[v].exp_err) begin
                out_ready = 1'b1;
                #1;
                chk("err_in_ready_low", in_ready, 0);
                tick();
                in_valid = 1'b0;
                chk("err_no_output", out_valid, 0);
            end else begin
                out_ready = 1'b0;
                #1;
                chk("run_in_ready", in_ready, 1);
                tick();
                in_valid = 1'b0;
                chk("vec_out_valid", out_valid, 1);
                chk("vec_out_chd", out_chd, vecs[v].exp_chd);
                out_ready = 1'b1;
                tick();
                chk("vec_out_drain", out_valid, 0);
            end
        end

        // Streaming 16 codewords with random backpressure.
        do_load(32'h67452301, 32'h01234567);
        chk("stream_load_done", cfg_done, 1);
        for (int i = 0; i < 16; i++) cws[i] = 8'($urandom);
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 16 && cyc < 400) begin
            out_ready   = 1'($urandom_range(0, 1));
            in_valid    = (sent < 16);
            in_codeword = (sent < 16) ? cws[sent] : 8'h00;
            #1;
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                if (exp_q.size() == 0) begin
                    chk("stream_spurious", out_chd, 32'hDEAD);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("stream_data", out_chd, exp_v);
                end
                rcvd++;
            end
            held   = out_valid && !out_ready;
            held_v = out_chd;
            if (hs_in) begin
                exp_q.push_back(model(32'h67452301, 32'h01234567, cws[sent]));
                sent++;
            end
            tick();
            if (held) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_chd, held_v);
            end
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_count", rcvd, 16);
        chk("stream_queue_empty", exp_q.size(), 0);
        out_ready = 1'b1;
        tick();

        // Reload from RUN while an output is held under backpressure.
        in_valid    = 1'b1;
        in_codeword = 8'h3C;
        out_ready   = 1'b0;
        tick();
        chk("held_before_reload", out_valid, 1);
        do_load(32'h76543210, 32'h76543210);
        in_valid = 1'b0;
        chk("reload_done", cfg_done, 1);
        chk("reload_no_output", out_valid, 0);

        // Asynchronous reset while holding an output.
        in_valid    = 1'b1;
        in_codeword = 8'hC3;
        out_ready   = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_out_chd", out_chd, 8'hC3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_chd", out_chd, 0);
        chk("async_rst_done", cfg_done, 0);
        #3;
        rst = 1'b0;
        tick();

        // Asynchronous reset at load index 4, then entries without a start.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1;
            cfg_lam1  = 3'(i);
            cfg_lam2  = 3'(i);
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midload_rst_done", cfg_done, 0);
        chk("midload_rst_err", cfg_err, 0);
        chk("midload_rst_out_chd", out_chd, 0);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            cfg_valid = 1'b1;
            cfg_lam1  = 3'(i);
            cfg_lam2  = 3'(i);
            tick();
        end
        cfg_valid = 1'b0;
        chk("idle_ignores_valid_done", cfg_done, 0);
        chk("idle_ignores_valid_err", cfg_err, 0);
        chk("idle_in_ready_low", in_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
